// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the reaction game sequencer
package game_pkg;

  localparam int SCORE_W = 8;
  localparam int TIME_W  = 8;
  localparam int PHASE_W = 3;

  localparam int DEF_TICKS_PER_SEC     = 50_000_000;
  localparam int DEF_COUNTDOWN_SECONDS = 3;
  localparam int DEF_GAME_SECONDS      = 30;

  // Enum values double as the externally visible phase code.
  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_COMMIT    = 3'd3,
    ST_DONE      = 3'd4
  } game_state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second tick divider with synchronous restart
module tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - round sequencer: countdown, play timer, score gating, leaderboard
module game_controller
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC     = DEF_TICKS_PER_SEC,
  parameter int COUNTDOWN_SECONDS = DEF_COUNTDOWN_SECONDS,
  parameter int GAME_SECONDS      = DEF_GAME_SECONDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  output logic               enA,
  output logic               clear_score,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] lb1,
  output logic [SCORE_W-1:0] lb2,
  output logic [SCORE_W-1:0] lb3,
  output logic               new_high,
  output logic [PHASE_W-1:0] phase
);

  game_state_t state;
  logic start_q;
  logic armed;
  logic commit_second;
  logic tick;
  logic start_rise;
  logic last_sec;
  logic state_change;

  // armed blocks a start held high through reset release from looking like a press.
  assign start_rise = start & ~start_q & armed;
  assign last_sec   = (time_left == TIME_W'(1));
  assign phase      = state;

  always_comb begin
    state_change = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: state_change = start_rise;
      ST_COUNTDOWN,
      ST_PLAY:          state_change = tick & last_sec;
      ST_COMMIT:        state_change = commit_second;
      default:          state_change = 1'b1;
    endcase
  end

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .clr  (state_change),
    .tick (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      start_q       <= 1'b0;
      armed         <= 1'b0;
      commit_second <= 1'b0;
      enA           <= 1'b0;
      clear_score   <= 1'b0;
      new_high      <= 1'b0;
      time_left     <= '0;
      lb1           <= '0;
      lb2           <= '0;
      lb3           <= '0;
    end else begin
      start_q     <= start;
      clear_score <= 1'b0;
      if (!start) begin
        armed <= 1'b1;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            state       <= ST_COUNTDOWN;
            time_left   <= TIME_W'(COUNTDOWN_SECONDS);
            clear_score <= 1'b1;
            new_high    <= 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (last_sec) begin
              state     <= ST_PLAY;
              time_left <= TIME_W'(GAME_SECONDS);
              enA       <= 1'b1;
            end else begin
              time_left <= time_left - 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (last_sec) begin
              state         <= ST_COMMIT;
              time_left     <= '0;
              enA           <= 1'b0;
              commit_second <= 1'b0;
            end else begin
              time_left <= time_left - 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          // First cycle lets the datapath's last enabled increment settle.
          if (!commit_second) begin
            commit_second <= 1'b1;
          end else begin
            commit_second <= 1'b0;
            state         <= ST_DONE;
            if (score != '0) begin
              if (score > lb1) begin
                lb3      <= lb2;
                lb2      <= lb1;
                lb1      <= score;
                new_high <= 1'b1;
              end else if (score > lb2) begin
                lb3 <= lb2;
                lb2 <= score;
              end else if (score > lb3) begin
                lb3 <= score;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          enA   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - scoreboard bench for game_controller with short timing parameters
module tb_game_controller;
  import game_pkg::*;

  localparam int TPS  = 4;
  localparam int CD   = 3;
  localparam int GAME = 5;

  typedef struct {
    logic [7:0] l1;
    logic [7:0] l2;
    logic [7:0] l3;
    logic       nh;
  } lb_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] score;
  logic       enA;
  logic       clear_score;
  logic [7:0] time_left;
  logic [7:0] lb1, lb2, lb3;
  logic       new_high;
  logic [2:0] phase;

  int n_vec = 0;
  int n_err = 0;
  lb_t exp_q[$];
  logic [7:0] m1 = 0, m2 = 0, m3 = 0;

  game_controller #(
    .TICKS_PER_SEC    (TPS),
    .COUNTDOWN_SECONDS(CD),
    .GAME_SECONDS     (GAME)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .score      (score),
    .enA        (enA),
    .clear_score(clear_score),
    .time_left  (time_left),
    .lb1        (lb1),
    .lb2        (lb2),
    .lb3        (lb3),
    .new_high   (new_high),
    .phase      (phase)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] sc);
    lb_t e;
    e.nh = 1'b0;
    if (sc != 0) begin
      if (sc > m1) begin
        m3 = m2; m2 = m1; m1 = sc; e.nh = 1'b1;
      end else if (sc > m2) begin
        m3 = m2; m2 = sc;
      end else if (sc > m3) begin
        m3 = sc;
      end
    end
    e.l1 = m1; e.l2 = m2; e.l3 = m3;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pop one expected leaderboard each time the DUT enters DONE.
  logic [2:0] prev_phase = 3'd0;
  always @(posedge clock) begin
    #1;
    if (phase == ST_DONE && prev_phase == ST_COMMIT) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        lb_t e;
        e = exp_q.pop_front();
        check("lb1", lb1, e.l1);
        check("lb2", lb2, e.l2);
        check("lb3", lb3, e.l3);
        check("new_high", new_high, e.nh);
        check("done_time_left", time_left, 0);
        check("done_enA", enA, 0);
      end
    end
    prev_phase = phase;
  end

  task automatic step(input logic st);
    @(negedge clock);
    start = st;
    @(posedge clock);
    #1;
  endtask

  task automatic run_round(input logic [7:0] sc, input bit toggle);
    int k;
    int pulses;
    int en_cycles;
    push_expected(sc);
    score = sc;
    step(1'b1);
    check("cs_pulse", clear_score, 1);
    check("phase_countdown", phase, ST_COUNTDOWN);
    check("tl_start", time_left, CD);
    check("nh_cleared", new_high, 0);
    pulses = 0;
    k = 0;
    while (!enA && k < 200) begin
      step(toggle ? ((k % 3) == 1) : 1'b0);
      k++;
      if (clear_score) pulses++;
      if (k == 4) check("tl_cd_4", time_left, CD - 1);
      if (k == 8) check("tl_cd_8", time_left, CD - 2);
    end
    check("countdown_len", k, CD * TPS);
    check("tl_play_start", time_left, GAME);
    en_cycles = 0;
    while (enA && en_cycles < 200) begin
      en_cycles++;
      step(toggle ? ((en_cycles % 4) == 2) : 1'b0);
      if (clear_score) pulses++;
    end
    check("play_len", en_cycles, GAME * TPS);
    check("phase_commit", phase, ST_COMMIT);
    check("tl_commit", time_left, 0);
    k = 0;
    while (phase != ST_DONE && k < 10) begin
      step(1'b0);
      k++;
    end
    check("commit_len", k, 2);
    check("no_extra_clear", pulses, 0);
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    reset = 1'b0;
    start = 1'b0;
    score = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_phase", phase, ST_IDLE);
    check("rst_enA", enA, 0);
    check("rst_clear", clear_score, 0);
    check("rst_time", time_left, 0);
    check("rst_lb1", lb1, 0);
    check("rst_lb3", lb3, 0);
    check("rst_nh", new_high, 0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0);
    step(1'b0);

    run_round(8'd17, 1'b0);

    // Reset mid-play with start held high through release.
    score = 8'd30;
    step(1'b1);
    k = 0;
    while (!enA && k < 200) begin step(1'b1); k++; end
    repeat (3) step(1'b1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_enA", enA, 0);
    check("arst_lb1", lb1, 0);
    check("arst_phase", phase, ST_IDLE);
    check("arst_time", time_left, 0);
    m1 = 0; m2 = 0; m3 = 0;
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (8) begin
      step(1'b1);
      if (phase != ST_IDLE || clear_score) bad++;
    end
    check("held_start_ignored", bad, 0);
    step(1'b0);
    step(1'b0);

    run_round(8'd10, 1'b0);
    run_round(8'd20, 1'b0);
    run_round(8'd15, 1'b0);
    run_round(8'd5, 1'b0);
    run_round(8'd15, 1'b0);
    run_round(8'd9, 1'b0);
    run_round(8'd0, 1'b1);
    run_round(8'd16, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencer for the reaction game. Runs the countdown and play timer, and gates the scoring datapath through `enA`. Clears the datapath score before each round. Commits the final score into a sorted three-entry leaderboard (`lb1`..`lb3`), which feeds the seven-segment display decoders.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per game second.
- `COUNTDOWN_SECONDS`, default 3: pre-round countdown length, 1..255.
- `GAME_SECONDS`, default 30: round length, 1..255.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it clears all state immediately.
- `start` in 1: debounced, synchronous player button; acted on at its rising edge only.
- `score` in 8: current count from the scoring datapath.
- `enA` out 1: scoring enable to the datapath; high only in PLAY.
- `clear_score` out 1: one-cycle pulse to the datapath's active-high synchronous clear.
- `time_left` out 8: seconds remaining in the current phase, for display.
- `lb1`, `lb2`, `lb3` out 8: leaderboard, highest first; `lb1 >= lb2 >= lb3` always.
- `new_high` out 1: high in DONE when the last score became the new `lb1`.
- `phase` out 3: state encoding, for LEDs and debug.

## Operation
- States: IDLE, COUNTDOWN, PLAY, COMMIT, DONE.
- `start_rise = start & ~start_q`, with `start_q` a registered copy of `start`.
- IDLE or DONE, on `start_rise`:
  - Go to COUNTDOWN; `time_left <= COUNTDOWN_SECONDS`.
  - Pulse `clear_score` for exactly that cycle.
  - Clear `new_high`.
- `start_rise` in COUNTDOWN, PLAY or COMMIT is ignored; a round cannot be restarted mid-play.
- COUNTDOWN, on each second tick:
  - If `time_left == 1`: go to PLAY, `time_left <= GAME_SECONDS`, `enA <= 1`.
  - Otherwise: decrement `time_left`.
- PLAY, on each second tick:
  - If `time_left == 1`: `time_left <= 0`, `enA <= 0`, go to COMMIT.
  - Otherwise: decrement `time_left`.
- COMMIT lasts exactly 2 cycles. The first cycle lets the datapath's final enabled update land. In the second cycle, `score` is sampled and inserted into the leaderboard; the FSM then goes to DONE.
- Insertion rule, strict greater-than; ties rank below existing entries:
  - `score > lb1`: `lb3<=lb2`, `lb2<=lb1`, `lb1<=score`, `new_high<=1`.
  - else `score > lb2`: `lb3<=lb2`, `lb2<=score`.
  - else `score > lb3`: `lb3<=score`.
  - else: no change.
- A score of 0 is never inserted.
- DONE holds `time_left=0`, `enA=0` and the leaderboard until the next `start_rise`.
- The leaderboard survives across rounds and is cleared only by `reset`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `enA=0`, `clear_score=0`, `new_high=0`.
  - `time_left=0`, `lb1=lb2=lb3=0`.
  - `phase` = IDLE code, `start_q=0`.
  - Tick counter at 0.
- Tick counter:
  - Counts 0..`TICKS_PER_SEC-1` and asserts tick when it reaches `TICKS_PER_SEC-1`.
  - Forced to 0 on every state transition, so each phase's first second is a full `TICKS_PER_SEC` cycles.
- Phase lengths:
  - COUNTDOWN: exactly `COUNTDOWN_SECONDS*TICKS_PER_SEC` cycles.
  - PLAY: exactly `GAME_SECONDS*TICKS_PER_SEC` cycles of `enA=1`.
- All outputs are registered.
- `enA` rises on the same edge that enters PLAY and falls on the edge that enters COMMIT.
- Leaderboard values update on the edge leaving COMMIT, which is 2 cycles after `enA` falls.
- Reset asserted mid-round: all outputs go to reset values immediately (asynchronous). After release, the FSM waits in IDLE for a fresh `start_rise`; a `start` held high through release does not trigger a round.

## Structure
- Package `game_pkg`:
  - state enum `game_state_t`, including the `phase` encoding;
  - score width constant `SCORE_W = 8`;
  - default timing constants.
- Sub-module `tick_gen`:
  - Parameter `TICKS_PER_SEC`; inputs `clock`, `reset`, `clr`; output `tick`.
  - Counter width is `$clog2(TICKS_PER_SEC)`.
- Leaderboard insertion stays inline in `game_controller`.

## Test plan
Bench parameters: `TICKS_PER_SEC=4`, `COUNTDOWN_SECONDS=3`, `GAME_SECONDS=5`.
- `start` pulse from IDLE -> `clear_score` high 1 cycle; `time_left` reads 3,2,1 at 4-cycle spacing; `enA` rises exactly 12 cycles after the start edge.
- Full round with `score` driven to 17 -> `enA` high exactly 20 cycles; 2 cycles after `enA` falls, `lb1=17`, `new_high=1`, phase DONE.
- Rounds scoring 10, 20, 15, 5 in order -> leaderboard ends at `lb1=20`, `lb2=15`, `lb3=10`; `new_high` high after the 10 and 20 rounds only.
- Tie: leaderboard 20/15/10 and a round scoring 15 -> result 20/15/15. A following round scoring 9 -> no change.
- `start` toggled during COUNTDOWN and PLAY -> no restart, no `clear_score` pulse, phase lengths unchanged.
- `reset` asserted mid-PLAY with `start` held high through release -> immediately `enA=0` and `lb*=0`; FSM stays in IDLE until `start` falls and rises again.
